// File: rtl/intr_ctrl_if.sv
// Data-side bus between the CPU and the interrupt controller register window.
interface intr_ctrl_if;
    logic [31:0] address;
    logic [31:0] data;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] rd_data;
    logic        IntAddress;

    modport master (
        output address, data, MemRead, MemWrite,
        input  rd_data, IntAddress
    );

    modport slave (
        input  address, data, MemRead, MemWrite,
        output rd_data, IntAddress
    );
endinterface

// File: rtl/intr_ctrl.sv
// Interrupt controller: pending/mask/edge registers and a claim/EOI window.
// A small REQ/SERVICE handshake with cp0 is added on top.
module intr_ctrl #(
    parameter int unsigned NSRC = 4,
    parameter logic [31:0] BASE = 32'hFFFF0040
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] irq_in,
    input  logic            IntAck,
    output logic            InterruptOut,
    output logic [2:0]      int_id,
    intr_ctrl_if.slave      bus
);
    typedef enum logic [1:0] {StIdle, StReq, StService} state_e;

    state_e          state_q, state_d;
    logic [NSRC-1:0] pending_q, pending_d;
    logic [NSRC-1:0] mask_q, mask_d;
    logic [NSRC-1:0] edge_q, edge_d;
    logic [NSRC-1:0] irq_prev_q;
    logic [2:0]      int_id_q, int_id_d;

    logic            hit;
    logic            wr_en;
    logic [1:0]      offset;
    logic [NSRC-1:0] set_vec;
    logic [NSRC-1:0] active;
    logic [7:0]      active_ext;
    logic [7:0]      edge_ext;
    logic [7:0]      ack_clr_ext;
    logic [2:0]      win_id;
    logic            ack_clr;
    logic            unused_bits;

    assign hit            = (bus.address[31:4] == BASE[31:4]);
    assign bus.IntAddress = hit;
    assign offset         = bus.address[3:2];
    assign wr_en          = bus.MemWrite && hit;
    // Edge sources need a 0->1 transition; level sources set whenever high.
    assign set_vec        = (edge_q & irq_in & ~irq_prev_q) | (~edge_q & irq_in);
    assign active         = pending_q & mask_q;
    assign active_ext     = 8'(active);
    assign edge_ext       = 8'(edge_q);
    assign ack_clr_ext    = ack_clr ? (8'd1 << int_id_q) : 8'd0;
    assign InterruptOut   = (state_q == StReq);
    assign int_id         = int_id_q;
    assign unused_bits    = ^{bus.address[1:0], bus.data};

    // Lowest-indexed active source wins.
    always_comb begin
        win_id = 3'd0;
        for (int i = int'(NSRC) - 1; i >= 0; i--) begin
            if (active[i]) win_id = 3'(i);
        end
    end

    // Next-state logic for the request/service handshake.
    always_comb begin
        state_d  = state_q;
        int_id_d = int_id_q;
        ack_clr  = 1'b0;
        case (state_q)
            StIdle: begin
                if (active != '0) begin
                    state_d  = StReq;
                    int_id_d = win_id;
                end
            end
            StReq: begin
                if (IntAck) begin
                    state_d = StService;
                    ack_clr = edge_ext[int_id_q];
                end else if (!active_ext[int_id_q]) begin
                    state_d = StIdle;
                end
            end
            StService: begin
                if (wr_en && offset == 2'd3) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Register next values; a set condition overrides W1C and ack clears.
    always_comb begin
        pending_d = pending_q;
        mask_d    = mask_q;
        edge_d    = edge_q;
        if (wr_en && offset == 2'd0) pending_d = pending_d & ~bus.data[NSRC-1:0];
        if (wr_en && offset == 2'd1) mask_d = bus.data[NSRC-1:0];
        if (wr_en && offset == 2'd2) edge_d = bus.data[NSRC-1:0];
        pending_d = pending_d & ~ack_clr_ext[NSRC-1:0];
        pending_d = pending_d | set_vec;
    end

    // Combinational register read port.
    always_comb begin
        bus.rd_data = 32'd0;
        if (bus.MemRead && hit) begin
            case (offset)
                2'd0:    bus.rd_data = 32'(pending_q);
                2'd1:    bus.rd_data = 32'(mask_q);
                2'd2:    bus.rd_data = 32'(edge_q);
                default: bus.rd_data = {state_q == StService, 28'd0, int_id_q};
            endcase
        end
    end

    // State and register update with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StIdle;
            pending_q  <= '0;
            mask_q     <= '0;
            edge_q     <= '0;
            irq_prev_q <= '0;
            int_id_q   <= 3'd0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            edge_q     <= edge_d;
            irq_prev_q <= irq_in;
            int_id_q   <= int_id_d;
        end
    end
endmodule

// File: tb/tb_intr_ctrl.sv
// Self-checking bench for intr_ctrl: directed scenarios then random traffic.
module tb_intr_ctrl;
    localparam logic [31:0] BASE = 32'hFFFF0040;
    localparam logic [31:0] IDLE_ADDR = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  irq;
    logic        ack;
    logic [31:0] addr, wdata;
    logic        mrd, mwr;
    logic        int_out;
    logic [2:0]  int_id;

    int tests = 0;
    int failed = 0;

    // Reference model: phase 0 = idle, 1 = requesting, 2 = in service.
    int       m_state;
    int       m_id;
    bit [3:0] m_pend, m_mask, m_edge, m_prev;

    always #5 clk = ~clk;

    intr_ctrl_if bus ();
    assign bus.address  = addr;
    assign bus.data     = wdata;
    assign bus.MemRead  = mrd;
    assign bus.MemWrite = mwr;

    intr_ctrl #(.NSRC(4), .BASE(BASE)) dut (
        .clk          (clk),
        .reset        (reset),
        .irq_in       (irq),
        .IntAck       (ack),
        .InterruptOut (int_out),
        .int_id       (int_id),
        .bus          (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit in_window();
        return addr[31:4] == BASE[31:4];
    endfunction

    function automatic logic [31:0] model_rd();
        if (!(mrd && in_window())) return 32'd0;
        case (addr[3:2])
            2'd0:    return {28'd0, m_pend};
            2'd1:    return {28'd0, m_mask};
            2'd2:    return {28'd0, m_edge};
            default: return ((m_state == 2) ? 32'h8000_0000 : 32'd0) | 32'(m_id);
        endcase
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, "_irqout"}, 32'(int_out), (m_state == 1) ? 32'd1 : 32'd0);
        chk({tag, "_intid"}, 32'(int_id), 32'(m_id));
        chk({tag, "_intaddr"}, 32'(bus.IntAddress), 32'(in_window()));
        chk({tag, "_rddata"}, bus.rd_data, model_rd());
    endtask

    // Advance one clock, applying the rules to the inputs held before the edge.
    task automatic step(input string tag);
        bit [3:0] np, nm, ne;
        int       ns, nid;
        bit       wr;
        wr  = mwr && in_window();
        np  = m_pend;
        nm  = m_mask;
        ne  = m_edge;
        ns  = m_state;
        nid = m_id;
        for (int i = 0; i < 4; i++) begin
            bit setc, clr;
            setc = m_edge[i] ? (irq[i] && !m_prev[i]) : irq[i];
            clr  = (wr && addr[3:2] == 2'd0 && wdata[i]) ||
                   (m_state == 1 && ack && m_id == i && m_edge[i]);
            if (setc) np[i] = 1'b1;
            else if (clr) np[i] = 1'b0;
        end
        if (wr && addr[3:2] == 2'd1) nm = wdata[3:0];
        if (wr && addr[3:2] == 2'd2) ne = wdata[3:0];
        if (m_state == 0) begin
            for (int i = 3; i >= 0; i--) begin
                if (m_pend[i] && m_mask[i]) begin
                    ns  = 1;
                    nid = i;
                end
            end
        end else if (m_state == 1) begin
            if (ack) ns = 2;
            else if (!(m_pend[m_id] && m_mask[m_id])) ns = 0;
        end else begin
            if (wr && addr[3:2] == 2'd3) ns = 0;
        end
        @(posedge clk);
        #1;
        if (!reset) begin
            m_pend = '0; m_mask = '0; m_edge = '0; m_prev = '0; m_state = 0; m_id = 0;
        end else begin
            m_pend = np; m_mask = nm; m_edge = ne; m_prev = irq; m_state = ns; m_id = nid;
        end
        check_outputs(tag);
    endtask

    task automatic wr_reg(input int off, input logic [31:0] val);
        addr  = BASE + 32'(off * 4);
        wdata = val;
        mwr   = 1'b1;
        step("wr");
        mwr   = 1'b0;
        addr  = IDLE_ADDR;
    endtask

    task automatic rd_chk(input int off, input string tag, input logic [31:0] lit);
        addr = BASE + 32'(off * 4);
        mrd  = 1'b1;
        #1;
        chk(tag, bus.rd_data, model_rd());
        chk({tag, "_lit"}, bus.rd_data, lit);
        mrd  = 1'b0;
        addr = IDLE_ADDR;
        #1;
    endtask

    initial begin
        reset = 1'b0; irq = '0; ack = 1'b0; addr = IDLE_ADDR; wdata = '0;
        mrd = 1'b0; mwr = 1'b0;
        m_pend = '0; m_mask = '0; m_edge = '0; m_prev = '0; m_state = 0; m_id = 0;

        // Reset state
        step("rst");
        step("rst");
        rd_chk(0, "rst_pend", 32'd0);
        rd_chk(1, "rst_mask", 32'd0);
        rd_chk(2, "rst_edge", 32'd0);
        rd_chk(3, "rst_claim", 32'd0);
        reset = 1'b1;
        step("run");

        // Edge source 0: pending one cycle after the pulse, request one cycle later
        wr_reg(1, 32'd1);
        wr_reg(2, 32'd1);
        irq = 4'b0001;
        step("edge_pulse");
        rd_chk(0, "edge_pend", 32'd1);
        irq = 4'b0000;
        step("edge_req");
        chk("edge_req_out", 32'(int_out), 32'd1);
        chk("edge_req_id", 32'(int_id), 32'd0);

        // Acknowledge clears the edge-mode pending bit
        ack = 1'b1;
        step("ack");
        ack = 1'b0;
        chk("ack_out", 32'(int_out), 32'd0);
        rd_chk(0, "ack_pend", 32'd0);
        rd_chk(3, "ack_claim", 32'h8000_0000);
        wr_reg(3, 32'd0);

        // Level sources: lowest index wins, re-requests after EOI while still high
        wr_reg(2, 32'd0);
        wr_reg(1, 32'hF);
        irq = 4'b1010;
        step("lvl_set");
        step("lvl_req");
        chk("lvl_id", 32'(int_id), 32'd1);
        chk("lvl_out", 32'(int_out), 32'd1);
        ack = 1'b1;
        step("lvl_ack");
        ack = 1'b0;
        rd_chk(3, "lvl_claim", 32'h8000_0001);
        wr_reg(3, 32'hDEAD_BEEF);
        step("lvl_rereq");
        chk("lvl_rereq_out", 32'(int_out), 32'd1);
        chk("lvl_rereq_id", 32'(int_id), 32'd1);
        irq = 4'b0000;
        wr_reg(0, 32'hF);
        step("lvl_withdraw");
        chk("lvl_withdraw_out", 32'(int_out), 32'd0);

        // W1C and an edge on the same bit in the same cycle: set wins
        wr_reg(1, 32'd0);
        wr_reg(2, 32'd4);
        irq = 4'b0100;
        wr_reg(0, 32'd4);
        rd_chk(0, "w1c_race", 32'd4);
        irq = 4'b0000;
        wr_reg(0, 32'd4);
        rd_chk(0, "w1c_clear", 32'd0);

        // Masking while requesting withdraws the request
        wr_reg(2, 32'd0);
        wr_reg(1, 32'hF);
        irq = 4'b1000;
        step("mask_set");
        step("mask_req");
        chk("mask_req_id", 32'(int_id), 32'd3);
        wr_reg(1, 32'd0);
        step("mask_drop");
        chk("mask_drop_out", 32'(int_out), 32'd0);
        chk("mask_drop_id", 32'(int_id), 32'd3);
        irq = 4'b0000;

        // Reset during service
        wr_reg(1, 32'hF);
        irq = 4'b0001;
        step("svc_set");
        step("svc_req");
        ack = 1'b1;
        step("svc_ack");
        ack = 1'b0;
        irq = 4'b0000;
        reset = 1'b0;
        step("svc_rst");
        reset = 1'b1;
        chk("svc_rst_out", 32'(int_out), 32'd0);
        rd_chk(0, "svc_rst_pend", 32'd0);
        rd_chk(1, "svc_rst_mask", 32'd0);
        rd_chk(3, "svc_rst_claim", 32'd0);

        // Accesses outside the window are ignored
        addr = BASE + 32'd20; wdata = 32'hF; mwr = 1'b1; mrd = 1'b1;
        #1;
        chk("out_intaddr", 32'(bus.IntAddress), 32'd0);
        chk("out_rd", bus.rd_data, 32'd0);
        step("out_wr");
        addr = BASE - 32'd12;
        step("out_wr2");
        mwr = 1'b0; mrd = 1'b0; addr = IDLE_ADDR;
        rd_chk(1, "out_mask", 32'd0);
        rd_chk(2, "out_edge", 32'd0);

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            irq   = 4'($urandom);
            ack   = ($urandom_range(3) == 0);
            reset = ($urandom_range(63) != 0);
            if ($urandom_range(7) == 0) addr = $urandom;
            else addr = BASE + 32'($urandom_range(3) * 4) + 32'($urandom_range(3));
            wdata = $urandom;
            mwr   = ($urandom_range(4) == 0);
            mrd   = ($urandom_range(1) == 0);
            #1;
            check_outputs("rnd_pre");
            step("rnd");
        end
        reset = 1'b1; mwr = 1'b0; mrd = 1'b0; ack = 1'b0; addr = IDLE_ADDR;
        step("end");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/intr_ctrl.md
INTR_CTRL -- requirements
Module: intr_ctrl

Interface
REQ-001 Parameter NSRC, default 4, number of interrupt sources; legal range 1..8.
REQ-002 Parameter BASE, default 32'hFFFF0040, word-aligned base address of the 4-word register window.
REQ-003 clk  input  1  rising-edge clock; single clock domain.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on rising clk edge.
REQ-005 irq_in  input  NSRC  raw interrupt request lines from peripherals (bit 0 = timer).
REQ-006 address  input  32  data-side byte address from ALU output.
REQ-007 data  input  32  store data (rt register value).
REQ-008 MemRead  input  1  load strobe.
REQ-009 MemWrite  input  1  store strobe.
REQ-010 IntAck  input  1  one-cycle pulse from cp0 when the interrupt is taken.
REQ-011 rd_data  output  32  load data for a selected register; 32'h0 when not selected.
REQ-012 IntAddress  output  1  high when address[31:4] == BASE[31:4] (combinational); used to gate data memory.
REQ-013 InterruptOut  output  1  interrupt request to cp0.
REQ-014 int_id  output  3  index of the latched/in-service source; zero-extended when NSRC < 8.

Function
REQ-015 Register map, word offsets: +0 PENDING (R, W1C); +4 MASK (RW); +8 EDGE (RW; 1 = edge, 0 = level); +12 CLAIM/EOI (R = claim, W = end-of-interrupt).
REQ-016 Register reads are combinational: rd_data = selected register when MemRead && IntAddress, else 0.
REQ-017 Register writes take effect at the rising edge where MemWrite && IntAddress; only bits [NSRC-1:0] are stored, upper bits read 0.
REQ-018 Edge-mode source: pending bit sets at the edge where irq_in=1 and the registered previous irq_in=0.
REQ-019 Level-mode source: pending bit sets at any edge where irq_in=1.
REQ-020 W1C of PENDING clears the written-1 bits; if a set condition occurs on the same bit in the same cycle, set wins.
REQ-021 Priority: the lowest-indexed bit of (PENDING & MASK) wins.
REQ-022 FSM states: IDLE, REQ, SERVICE; InterruptOut = 1 only in REQ.
REQ-023 IDLE -> REQ at the edge where (PENDING & MASK) != 0; the winning index is latched into int_id (1-cycle latency from pending to InterruptOut).
REQ-024 REQ -> SERVICE on IntAck; if the latched source is in edge mode, its pending bit clears on that edge.
REQ-025 REQ -> IDLE if the latched bit of (PENDING & MASK) is 0 and IntAck is 0 (request withdrawn or masked); int_id holds its value.
REQ-026 SERVICE -> IDLE on an EOI write (any data value); re-arbitration starts the next cycle.
REQ-027 Events ignored: IntAck outside REQ; EOI outside SERVICE.
REQ-028 No preemption: a higher-priority pending source waits until the FSM returns to IDLE.
REQ-029 CLAIM read value: bit31 = (state == SERVICE), bits[2:0] = int_id, all other bits 0.
REQ-030 The block has no effect on data memory; it only asserts IntAddress.

Reset
REQ-031 While reset == 0 at a clock edge: state = IDLE, PENDING = 0, MASK = 0, EDGE = 0, int_id = 0, irq_in history = 0.
REQ-032 Reset has the same effect mid-REQ or mid-SERVICE: InterruptOut = 0 from the following cycle; no EOI is required.
REQ-033 After reset, a source held high produces no edge event until it falls and rises again. A level source sets its pending bit immediately.

Verification
REQ-034 Bench scenarios:
- MASK = 4'b0001, EDGE = 4'b0001; pulse irq_in[0] -> PENDING = 1 the next cycle; InterruptOut = 1 one cycle later; int_id = 0.
- State REQ, id 0 (edge mode); IntAck pulse -> PENDING[0] = 0; InterruptOut = 0; CLAIM reads 32'h80000000.
- MASK = 4'hF, level mode; irq_in = 4'b1010 -> int_id = 1; after EOI with irq_in[1] still high -> REQ again with int_id = 1.
- W1C of PENDING bit 2 in the same cycle as an edge on irq_in[2] -> PENDING[2] stays 1.
- In REQ, write MASK = 0 -> IDLE next cycle; InterruptOut = 0.
- reset = 0 during SERVICE -> IDLE, all registers 0; address outside the window -> IntAddress = 0, rd_data = 0, registers unchanged.
